gray_counter: RTL

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter_pkg.sv | 14 +
 rtl/gray_counter_gray2bin.sv | 14 +
 rtl/gray_counter.sv | 82 ++++++++
 3 files changed

// File: rtl/gray_counter_pkg.sv
// Shared encodings and the binary-to-Gray converter for the Gray counter slice.
package gray_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam bit   MODE_WRAP = 1'b1;
    localparam bit   MODE_SAT  = 1'b0;

    // Callers size the result back down to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_counter_gray2bin.sv
// Combinational Gray-to-binary decoder used on the load path.
module gray_counter_gray2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the parity of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray and binary outputs, wrap or
// saturate at the limits, and a terminal-count event flag.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MaxVal = '1;
    localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] load_dec;

    gray_counter_gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray_i (load_val),
        .bin_o  (load_dec)
    );

    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load) begin
            bin_d = load_gray ? load_dec : load_val;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (bin_q == MaxVal) begin
                    tc_d = 1'b1;
                    if (WRAP == MODE_WRAP) begin
                        bin_d = '0;
                    end
                end else begin
                    bin_d = bin_q + OneVal;
                end
            end else begin
                if (bin_q == '0) begin
                    tc_d = 1'b1;
                    if (WRAP == MODE_WRAP) begin
                        bin_d = MaxVal;
                    end
                end else begin
                    bin_d = bin_q - OneVal;
                end
            end
        end
        // Gray derives from the next binary so both registers update together.
        gray_d = WIDTH'(bin2gray(32'(bin_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign binary = bin_q;
    assign gray   = gray_q;
    assign tc     = tc_q;

endmodule
